// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave AXI4 single-beat arbiter.
// The read and write channels each have an independent three-state FSM.
// Each channel allows one outstanding transaction.
// Arbitration is either round-robin or fixed priority, where the lowest index wins.
module axi_rr_arbiter #(
    parameter int NUM_M     = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int PRIO_MODE = 0,
    localparam int GW       = $clog2(NUM_M),
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    // upstream masters: read
    input  logic [NUM_M-1:0]           m_arvalid,
    output logic [NUM_M-1:0]           m_arready,
    input  logic [NUM_M*ADDR_W-1:0]    m_araddr,
    output logic [NUM_M-1:0]           m_rvalid,
    input  logic [NUM_M-1:0]           m_rready,
    output logic [NUM_M*DATA_W-1:0]    m_rdata,
    output logic [NUM_M*2-1:0]         m_rresp,
    // upstream masters: write
    input  logic [NUM_M-1:0]           m_awvalid,
    output logic [NUM_M-1:0]           m_awready,
    input  logic [NUM_M*ADDR_W-1:0]    m_awaddr,
    input  logic [NUM_M-1:0]           m_wvalid,
    output logic [NUM_M-1:0]           m_wready,
    input  logic [NUM_M*DATA_W-1:0]    m_wdata,
    input  logic [NUM_M*STRB_W-1:0]    m_wstrb,
    output logic [NUM_M-1:0]           m_bvalid,
    input  logic [NUM_M-1:0]           m_bready,
    output logic [NUM_M*2-1:0]         m_bresp,
    // downstream slave
    output logic                       s_arvalid,
    input  logic                       s_arready,
    output logic [ADDR_W-1:0]          s_araddr,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    input  logic [DATA_W-1:0]          s_rdata,
    input  logic [1:0]                 s_rresp,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic [ADDR_W-1:0]          s_awaddr,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [STRB_W-1:0]          s_wstrb,
    input  logic                       s_bvalid,
    output logic                       s_bready,
    input  logic [1:0]                 s_bresp,
    // debug / performance
    output logic [GW-1:0]              rd_grant,
    output logic [GW-1:0]              wr_grant
);

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wr_state_e;

    rd_state_e       rd_state_q;
    wr_state_e       wr_state_q;
    logic [GW-1:0]   rd_grant_q, rd_ptr_q;
    logic [GW-1:0]   wr_grant_q, wr_ptr_q;
    logic            aw_done_q, w_done_q;
    logic [GW-1:0]   rd_pick_d, wr_pick_d;
    logic            ar_hs, r_hs, aw_hs, w_hs, b_hs;
    int              rg, wg;

    // Winner selection.
    // Round-robin scans from ptr+1 with wrap-around; fixed priority takes the lowest requester.
    // The loops run downward so that the last hit found is the first in scan order.
    function automatic logic [GW-1:0] arb_pick(input logic [NUM_M-1:0] req,
                                              input logic [GW-1:0]    ptr);
        logic [GW-1:0] win;
        int            idx;
        win = '0;
        if (PRIO_MODE == 1) begin
            for (int i = NUM_M - 1; i >= 0; i--) begin
                if (req[i]) win = GW'(i);
            end
        end else begin
            for (int k = NUM_M; k >= 1; k--) begin
                idx = (int'(ptr) + k) % NUM_M;
                if (req[idx]) win = GW'(idx);
            end
        end
        return win;
    endfunction

    assign rd_pick_d = arb_pick(m_arvalid, rd_ptr_q);
    assign wr_pick_d = arb_pick(m_awvalid, wr_ptr_q);
    assign rg        = int'(rd_grant_q);
    assign wg        = int'(wr_grant_q);
    assign rd_grant  = rd_grant_q;
    assign wr_grant  = wr_grant_q;

    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid  & s_rready;
    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid  & s_wready;
    assign b_hs  = s_bvalid  & s_bready;

    // Read FSM: arbitrate in idle, then hold the grant through the address and data phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            rd_grant_q <= '0;
            rd_ptr_q   <= GW'(NUM_M - 1);
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (|m_arvalid) begin
                        rd_grant_q <= rd_pick_d;
                        rd_state_q <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) rd_state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (r_hs) begin
                        rd_state_q <= RD_IDLE;
                        rd_ptr_q   <= rd_grant_q;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // Write FSM: AW and W of the winner run in parallel, and their done flags gate the move to the response phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
            wr_grant_q <= '0;
            wr_ptr_q   <= GW'(NUM_M - 1);
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (|m_awvalid) begin
                        wr_grant_q <= wr_pick_d;
                        wr_state_q <= WR_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                        wr_state_q <= WR_RESP;
                end
                WR_RESP: begin
                    if (b_hs) begin
                        wr_state_q <= WR_IDLE;
                        wr_ptr_q   <= wr_grant_q;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // Read routing: only the granted lane is connected, and every other lane sees zeros.
    always_comb begin
        m_arready = '0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        s_rready  = 1'b0;
        case (rd_state_q)
            RD_ADDR: begin
                s_arvalid     = m_arvalid[rg];
                s_araddr      = m_araddr[rg*ADDR_W +: ADDR_W];
                m_arready[rg] = s_arready;
            end
            RD_DATA: begin
                m_rvalid[rg]                 = s_rvalid;
                m_rdata[rg*DATA_W +: DATA_W] = s_rdata;
                m_rresp[rg*2 +: 2]           = s_rresp;
                s_rready                     = m_rready[rg];
            end
            default: ;
        endcase
    end

    // Write routing: a channel that has already handshaken is masked off towards both the slave and the master.
    always_comb begin
        m_awready = '0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        m_wready  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        s_bready  = 1'b0;
        case (wr_state_q)
            WR_ADDR: begin
                s_awvalid     = m_awvalid[wg] & ~aw_done_q;
                s_awaddr      = m_awaddr[wg*ADDR_W +: ADDR_W];
                m_awready[wg] = s_awready & ~aw_done_q;
                s_wvalid      = m_wvalid[wg] & ~w_done_q;
                s_wdata       = m_wdata[wg*DATA_W +: DATA_W];
                s_wstrb       = m_wstrb[wg*STRB_W +: STRB_W];
                m_wready[wg]  = s_wready & ~w_done_q;
            end
            WR_RESP: begin
                m_bvalid[wg]       = s_bvalid;
                m_bresp[wg*2 +: 2] = s_bresp;
                s_bready           = m_bready[wg];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter.
// Two 4-master instances share the same stimulus: u_rr is round-robin and u_fx is fixed priority.
module tb_axi_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // shared stimulus
    logic [3:0]   m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [127:0] m_araddr, m_awaddr;
    logic [255:0] m_wdata;
    logic [31:0]  m_wstrb;
    logic         s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [63:0]  s_rdata;
    logic [1:0]   s_rresp, s_bresp;

    // round-robin instance outputs
    logic [3:0]   m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [255:0] m_rdata;
    logic [7:0]   m_rresp, m_bresp;
    logic         s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [31:0]  s_araddr, s_awaddr;
    logic [63:0]  s_wdata;
    logic [7:0]   s_wstrb;
    logic [1:0]   rd_grant, wr_grant;

    // fixed-priority instance outputs
    logic [3:0]   f_arready, f_rvalid, f_awready, f_wready, f_bvalid;
    logic [255:0] f_rdata;
    logic [7:0]   f_rresp, f_bresp;
    logic         f_s_arvalid, f_s_rready, f_s_awvalid, f_s_wvalid, f_s_bready;
    logic [31:0]  f_s_araddr, f_s_awaddr;
    logic [63:0]  f_s_wdata;
    logic [7:0]   f_s_wstrb;
    logic [1:0]   f_rd_grant, f_wr_grant;

    int checks = 0;
    int errors = 0;

    axi_rr_arbiter #(.NUM_M(4), .ADDR_W(32), .DATA_W(64), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .rd_grant(rd_grant), .wr_grant(wr_grant)
    );

    axi_rr_arbiter #(.NUM_M(4), .ADDR_W(32), .DATA_W(64), .PRIO_MODE(1)) u_fx (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(f_arready), .m_araddr(m_araddr),
        .m_rvalid(f_rvalid), .m_rready(m_rready), .m_rdata(f_rdata), .m_rresp(f_rresp),
        .m_awvalid(m_awvalid), .m_awready(f_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(f_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(f_bvalid), .m_bready(m_bready), .m_bresp(f_bresp),
        .s_arvalid(f_s_arvalid), .s_arready(s_arready), .s_araddr(f_s_araddr),
        .s_rvalid(s_rvalid), .s_rready(f_s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(f_s_awvalid), .s_awready(s_awready), .s_awaddr(f_s_awaddr),
        .s_wvalid(f_s_wvalid), .s_wready(s_wready), .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(f_s_bready), .s_bresp(s_bresp),
        .rd_grant(f_rd_grant), .wr_grant(f_wr_grant)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_arvalid = '0; m_rready = 4'hF; m_awvalid = '0; m_wvalid = '0; m_bready = 4'hF;
        m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
        s_rdata = '0; s_rresp = '0; s_bresp = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic slave_zero_wait();
        s_arready = 1'b1; s_rvalid = 1'b1; s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        slave_zero_wait();
        m_arvalid = 4'hF; m_awvalid = 4'hF; m_wvalid = 4'hF;
        step();
        step();
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL reset_s_arvalid got=%0h exp=0", s_arvalid); end
        checks++; if (m_arready !== 4'h0) begin errors++; $display("FAIL reset_m_arready got=%0h exp=0", m_arready); end
        checks++; if (m_rvalid !== 4'h0 || m_bvalid !== 4'h0) begin errors++; $display("FAIL reset_rvalid_bvalid got=%0h/%0h exp=0/0", m_rvalid, m_bvalid); end
        checks++; if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0) begin errors++; $display("FAIL reset_aw_w got=%0h/%0h exp=0/0", s_awvalid, s_wvalid); end
        checks++; if (rd_grant !== 2'd0 || wr_grant !== 2'd0) begin errors++; $display("FAIL reset_grants got=%0d/%0d exp=0/0", rd_grant, wr_grant); end
        rst = 1'b0;
        clear_inputs();
        step();
    endtask

    task automatic test_read_two_masters();
        logic [255:0] exp_rdata;
        do_reset();
        slave_zero_wait();
        s_rdata = 64'hDEAD_BEEF_0000_0001;
        s_rresp = 2'b01;
        m_araddr[0 +: 32]  = 32'h8000_0000;
        m_araddr[32 +: 32] = 32'h8000_0004;
        m_arvalid = 4'b0011;
        #1;
        checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL rd2_arb_cycle got=%0h exp=0", s_arvalid); end
        step();
        checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000) begin errors++; $display("FAIL rd2_first_addr got=%0h/%0h exp=1/80000000", s_arvalid, s_araddr); end
        checks++; if (m_arready !== 4'b0001 || rd_grant !== 2'd0) begin errors++; $display("FAIL rd2_first_grant got=%0h/%0d exp=1/0", m_arready, rd_grant); end
        step();
        m_arvalid = 4'b0010;
        exp_rdata = '0;
        exp_rdata[0 +: 64] = 64'hDEAD_BEEF_0000_0001;
        checks++; if (m_rvalid !== 4'b0001 || m_rdata !== exp_rdata) begin errors++; $display("FAIL rd2_m0_data got=%0h/%0h exp=1/%0h", m_rvalid, m_rdata, exp_rdata); end
        checks++; if (m_rresp !== 8'b0000_0001 || s_rready !== 1'b1) begin errors++; $display("FAIL rd2_m0_resp got=%0h/%0h exp=1/1", m_rresp, s_rready); end
        step();
        checks++; if (s_arvalid !== 1'b0 || m_rvalid !== 4'h0) begin errors++; $display("FAIL rd2_idle got=%0h/%0h exp=0/0", s_arvalid, m_rvalid); end
        step();
        checks++; if (rd_grant !== 2'd1 || s_araddr !== 32'h8000_0004) begin errors++; $display("FAIL rd2_second got=%0d/%0h exp=1/80000004", rd_grant, s_araddr); end
        step();
        m_arvalid = 4'b0000;
        exp_rdata = '0;
        exp_rdata[64 +: 64] = 64'hDEAD_BEEF_0000_0001;
        checks++; if (m_rvalid !== 4'b0010 || m_rdata !== exp_rdata) begin errors++; $display("FAIL rd2_m1_data got=%0h/%0h exp=2/%0h", m_rvalid, m_rdata, exp_rdata); end
        step();
    endtask

    task automatic test_rr_rotation();
        logic [1:0] exp_g;
        logic [3:0] exp_v;
        do_reset();
        slave_zero_wait();
        for (int i = 0; i < 4; i++) m_araddr[i*32 +: 32] = 32'h1000_0000 + 32'(i * 16);
        m_arvalid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            exp_g = 2'(k % 4);
            exp_v = 4'b0001 << (k % 4);
            step();
            checks++; if (rd_grant !== exp_g || s_araddr !== 32'h1000_0000 + 32'(exp_g) * 32'd16) begin errors++; $display("FAIL rr_grant_%0d got=%0d/%0h exp=%0d", k, rd_grant, s_araddr, exp_g); end
            step();
            checks++; if (m_rvalid !== exp_v) begin errors++; $display("FAIL rr_rvalid_%0d got=%0h exp=%0h", k, m_rvalid, exp_v); end
            step();
        end
        m_arvalid = 4'h0;
        step();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        slave_zero_wait();
        for (int i = 0; i < 4; i++) m_araddr[i*32 +: 32] = 32'h2000_0000 + 32'(i * 16);
        m_arvalid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (f_rd_grant !== 2'd0 || f_s_araddr !== 32'h2000_0000) begin errors++; $display("FAIL fx_m0_wins_%0d got=%0d/%0h exp=0/20000000", k, f_rd_grant, f_s_araddr); end
            step();
            checks++; if (f_rvalid !== 4'b0001) begin errors++; $display("FAIL fx_rvalid_%0d got=%0h exp=1", k, f_rvalid); end
            step();
        end
        m_arvalid = 4'b0100;
        step();
        checks++; if (f_rd_grant !== 2'd2) begin errors++; $display("FAIL fx_m2_after got=%0d exp=2", f_rd_grant); end
        step();
        step();
        m_arvalid = 4'h0;
        step();
    endtask

    task automatic test_write_split();
        do_reset();
        s_awready = 1'b1; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b10;
        m_awaddr[32 +: 32] = 32'h4000_0040;
        m_wdata[64 +: 64]  = 64'h1122_3344_5566_7788;
        m_wstrb[8 +: 8]    = 8'hF0;
        m_awvalid = 4'b0010; m_wvalid = 4'b0010;
        step();
        checks++; if (wr_grant !== 2'd1 || s_awvalid !== 1'b1 || s_awaddr !== 32'h4000_0040) begin errors++; $display("FAIL wr_aw_fwd got=%0d/%0h/%0h exp=1/1/40000040", wr_grant, s_awvalid, s_awaddr); end
        checks++; if (m_awready !== 4'b0010 || m_wready !== 4'b0000) begin errors++; $display("FAIL wr_ready0 got=%0h/%0h exp=2/0", m_awready, m_wready); end
        checks++; if (s_wvalid !== 1'b1 || s_wdata !== 64'h1122_3344_5566_7788 || s_wstrb !== 8'hF0) begin errors++; $display("FAIL wr_w_fwd got=%0h/%0h/%0h", s_wvalid, s_wdata, s_wstrb); end
        step();
        m_awvalid = 4'b0000;
        checks++; if (s_awvalid !== 1'b0 || m_awready !== 4'h0 || s_wvalid !== 1'b1) begin errors++; $display("FAIL wr_aw_dropped got=%0h/%0h/%0h exp=0/0/1", s_awvalid, m_awready, s_wvalid); end
        step();
        checks++; if (s_bready !== 1'b0) begin errors++; $display("FAIL wr_no_early_resp got=%0h exp=0", s_bready); end
        step();
        s_wready = 1'b1;
        #1;
        checks++; if (m_wready !== 4'b0010) begin errors++; $display("FAIL wr_wready got=%0h exp=2", m_wready); end
        step();
        m_wvalid = 4'b0000;
        checks++; if (s_wvalid !== 1'b0 || s_bready !== 1'b1 || m_bvalid !== 4'h0) begin errors++; $display("FAIL wr_resp_phase got=%0h/%0h/%0h exp=0/1/0", s_wvalid, s_bready, m_bvalid); end
        s_bvalid = 1'b1;
        #1;
        checks++; if (m_bvalid !== 4'b0010 || m_bresp !== 8'b0000_1000) begin errors++; $display("FAIL wr_bresp got=%0h/%0h exp=2/08", m_bvalid, m_bresp); end
        step();
        s_bvalid = 1'b0;
        checks++; if (m_bvalid !== 4'h0 || m_bresp !== 8'h00) begin errors++; $display("FAIL wr_done got=%0h/%0h exp=0/0", m_bvalid, m_bresp); end
        step();
    endtask

    task automatic test_concurrent_rw();
        do_reset();
        slave_zero_wait();
        m_awvalid = 4'b0001; m_wvalid = 4'b0001; m_arvalid = 4'b0010;
        step();
        checks++; if (wr_grant !== 2'd0 || rd_grant !== 2'd1) begin errors++; $display("FAIL rw_grants got=%0d/%0d exp=0/1", wr_grant, rd_grant); end
        checks++; if (s_arvalid !== 1'b1 || s_awvalid !== 1'b1 || s_wvalid !== 1'b1) begin errors++; $display("FAIL rw_addr got=%0h/%0h/%0h exp=1/1/1", s_arvalid, s_awvalid, s_wvalid); end
        step();
        m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
        checks++; if (m_rvalid !== 4'b0010 || m_bvalid !== 4'b0001) begin errors++; $display("FAIL rw_resp got=%0h/%0h exp=2/1", m_rvalid, m_bvalid); end
        step();
        checks++; if (m_rvalid !== 4'h0 || m_bvalid !== 4'h0 || s_arvalid !== 1'b0 || s_awvalid !== 1'b0) begin errors++; $display("FAIL rw_idle got=%0h/%0h/%0h/%0h", m_rvalid, m_bvalid, s_arvalid, s_awvalid); end
        step();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        slave_zero_wait();
        s_rdata = 64'hCAFE_F00D_1234_5678;
        m_arvalid = 4'b0100;
        step();
        step();
        m_arvalid = 4'b0000;
        checks++; if (m_rvalid !== 4'b0100 || rd_grant !== 2'd2) begin errors++; $display("FAIL rst_pre_state got=%0h/%0d exp=4/2", m_rvalid, rd_grant); end
        rst = 1'b1;
        step();
        checks++; if (m_rvalid !== 4'h0 || m_rdata !== 256'h0 || s_rready !== 1'b0 || s_arvalid !== 1'b0) begin errors++; $display("FAIL rst_outputs got=%0h/%0h/%0h/%0h exp=0", m_rvalid, m_rdata, s_rready, s_arvalid); end
        checks++; if (rd_grant !== 2'd0 || m_arready !== 4'h0) begin errors++; $display("FAIL rst_grant got=%0d/%0h exp=0/0", rd_grant, m_arready); end
        rst = 1'b0;
        m_arvalid = 4'hF;
        step();
        checks++; if (rd_grant !== 2'd0 || s_arvalid !== 1'b1) begin errors++; $display("FAIL rst_next_m0 got=%0d/%0h exp=0/1", rd_grant, s_arvalid); end
        step();
        step();
        m_arvalid = 4'h0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_read_two_masters();
        test_rr_rotation();
        test_fixed_priority();
        test_write_split();
        test_concurrent_rw();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
